core_ctrl_endpoint: RTL
=======================

// Module: core_ctrl_endpoint
// PURPOSE
//  Core-side end of the scheduler control channel; one instance per core wrapper.
//  Consumes scheduler->core ctrl words: the reset command and loopback descriptors.
//  Produces core->scheduler ctrl words:
//   - slot-free (type 0)
//   - loopback descriptor (type 1)
//   - slot-count config (type 3)
//  The core-ID tuser on the outgoing stream is added by the ctrl switch, not here.
// PARAMETERS
//  DATA_WIDTH       64   ctrl word width; msg_type = tdata[DATA_WIDTH-1 -: 4]
//  SLOT_COUNT       8    slots this core offers; sent in the config message
//  LEN_WIDTH        16   length field width in slot-free messages
//  SLOT_WIDTH       $clog2(SLOT_COUNT+1)   slot number width; slots are 1..SLOT_COUNT
//  RST_HOLD_CYCLES  16   cycles core_rst stays high after a reset command (>=1)
// PORTS
//  clk             in   1                 clock
//  rst             in   1                 synchronous, active-high reset
//  ctrl_s_tdata    in   DATA_WIDTH        scheduler->core word
//  ctrl_s_tvalid   in   1
//  ctrl_s_tready   out  1
//  ctrl_s_tlast    in   1                 always 1; ignored
//  ctrl_m_tdata    out  DATA_WIDTH        core->scheduler word
//  ctrl_m_tvalid   out  1
//  ctrl_m_tready   in   1
//  ctrl_m_tlast    out  1                 constant 1
//  desc_tdata      out  DATA_WIDTH        descriptor to core (top byte 0)
//  desc_tvalid     out  1
//  desc_tready     in   1
//  free_valid      in   1                 core returns a slot
//  free_slot       in   SLOT_WIDTH
//  free_len        in   LEN_WIDTH
//  free_ready      out  1
//  lb_valid        in   1                 core sends a loopback descriptor
//  lb_data         in   DATA_WIDTH-4      payload; the type nibble is added here
//  lb_ready        out  1
//  core_rst        out  1                 reset to the core
//  err_bad_slot    out  1                 1-cycle pulse
//  err_drop_desc   out  1                 1-cycle pulse
// BEHAVIOUR
//  Reset values: ctrl_m_tvalid=0, desc_tvalid=0, core_rst=1, err_*=0, state=WAIT_CMD.
//  Reset command: ctrl_s_tdata == 64'hFFFFFFFF_FFFFFFFE. Recognised in every state; ctrl_s_tready=1 for it.
//  FSM:
//   - WAIT_CMD: core_rst=1. Reset cmd -> HOLD with hold counter loaded.
//   - HOLD: core_rst=1; counter counts RST_HOLD_CYCLES; reset cmd reloads it; expiry -> CFG.
//   - CFG: core_rst=0. Load config word {4'd3, zeros, SLOT_COUNT[SLOT_WIDTH-1:0]} into the output register.
//     On handshake -> RUN. If the output register is busy, wait for it to drain first.
//   - RUN: normal operation. Reset cmd -> HOLD with core_rst=1 from the next cycle.
//  Descriptor path:
//   - Non-reset words in RUN: desc_tdata=ctrl_s_tdata, desc_tvalid=ctrl_s_tvalid, ctrl_s_tready=desc_tready.
//     Combinational pass-through, 0 latency.
//   - Non-reset words outside RUN: accepted (tready=1), dropped, err_drop_desc pulses.
//  Outgoing messages:
//   - Single output register; registered, 1-cycle latency from input handshake to ctrl_m_tvalid.
//   - Loading allowed when the register is empty or is handshaking this cycle (full throughput).
//   - Valid/data held stable until ctrl_m_tready. A message in flight completes even across a reset cmd.
//   - Priority: CFG message first. free vs lb: 2-port round-robin; the winner gets ready.
//   - free_ready and lb_ready are 0 outside RUN.
//  Slot-free word: [63:60]=0, [LEN_WIDTH+SLOT_WIDTH-1:LEN_WIDTH]=free_slot, [LEN_WIDTH-1:0]=free_len, rest 0.
//  free_slot==0 or >SLOT_COUNT: the word is consumed (free_ready=1) but not sent; err_bad_slot pulses.
//  Loopback word: {4'd1, lb_data}.
//  rst mid-message: ctrl_m_tvalid drops and the FSM returns to WAIT_CMD; the scheduler is reset with it.
// STRUCTURE
//  Shared package: MSG_SLOT_FREE=4'd0, MSG_LOOPBACK=4'd1, MSG_SLOT_CFG=4'd3,
//   CORE_RST_CMD=64'hFFFFFFFF_FFFFFFFE, FSM state encodings.
//  Sub-module: the existing round-robin `arbiter` (PORTS=2) for free vs lb.
//  FSM and output register stay inline.
// TESTING
//  1. Startup: send reset cmd -> core_rst high for 16 cycles; then ctrl_m word 0x3000_0000_0000_0008; RUN.
//  2. Slot free: slot 5, len 0x05EE -> ctrl_m_tdata=0x0000_0000_0005_05EE one cycle later.
//     Also check ctrl_m_tready=0 for 3 cycles -> word held stable.
//  3. Contention: free_valid and lb_valid both held high for 4 grants -> alternating free/lb words.
//     Back-to-back: ctrl_m_tvalid stays high continuously.
//  4. Bad slot: free_slot=0, then 9 (SLOT_COUNT=8) -> no ctrl_m words; err_bad_slot pulses twice.
//  5. Reset cmd mid-RUN while a lb word is stalled -> lb word completes on tready.
//     Also: core_rst re-asserts, then the config word is resent after the hold.
//  6. Descriptor 0x0012_3456_789A_BCDE while in HOLD -> dropped with err_drop_desc.
//     Same descriptor in RUN -> appears on desc_tdata the same cycle.

Source files
------------

// File: rtl/core_ctrl_endpoint_pkg.sv
// Shared definitions for the core-side scheduler control endpoint.
package core_ctrl_endpoint_pkg;

  localparam logic [3:0]  MSG_SLOT_FREE = 4'd0;
  localparam logic [3:0]  MSG_LOOPBACK  = 4'd1;
  localparam logic [3:0]  MSG_SLOT_CFG  = 4'd3;
  localparam logic [63:0] CORE_RST_CMD  = 64'hFFFF_FFFF_FFFF_FFFE;

  typedef enum logic [1:0] {
    ST_WAIT_CMD = 2'd0,
    ST_HOLD     = 2'd1,
    ST_CFG      = 2'd2,
    ST_RUN      = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/core_ctrl_endpoint_arbiter.sv
// Round-robin arbiter: the port after the most recently acknowledged winner has priority.
module arbiter #(
  parameter int unsigned PORTS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] req_i,
  input  logic             ack_i,
  output logic [PORTS-1:0] grant_o
);

  localparam int unsigned IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] win;
  logic             found;
  int unsigned      idx;

  always_comb begin
    grant_o = '0;
    win     = last_q;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= PORTS; k++) begin
      idx = (32'(last_q) + k) % PORTS;
      if (!found && req_i[IDX_W'(idx)]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
    if (found) grant_o[win] = 1'b1;
    last_d = (ack_i && found) ? win : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= IDX_W'(PORTS - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/core_ctrl_endpoint.sv
// Core-side end of the scheduler control channel: reset/config sequencing,
// descriptor pass-through and slot-free/loopback message generation.
module core_ctrl_endpoint
  import core_ctrl_endpoint_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned SLOT_COUNT      = 8,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned SLOT_WIDTH      = $clog2(SLOT_COUNT + 1),
  parameter int unsigned RST_HOLD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ctrl_s_tdata,
  input  logic                  ctrl_s_tvalid,
  output logic                  ctrl_s_tready,
  input  logic                  ctrl_s_tlast,
  output logic [DATA_WIDTH-1:0] ctrl_m_tdata,
  output logic                  ctrl_m_tvalid,
  input  logic                  ctrl_m_tready,
  output logic                  ctrl_m_tlast,
  output logic [DATA_WIDTH-1:0] desc_tdata,
  output logic                  desc_tvalid,
  input  logic                  desc_tready,
  input  logic                  free_valid,
  input  logic [SLOT_WIDTH-1:0] free_slot,
  input  logic [LEN_WIDTH-1:0]  free_len,
  output logic                  free_ready,
  input  logic                  lb_valid,
  input  logic [DATA_WIDTH-5:0] lb_data,
  output logic                  lb_ready,
  output logic                  core_rst,
  output logic                  err_bad_slot,
  output logic                  err_drop_desc
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD_CYCLES - 1);

  ctrl_state_e           state_q, state_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                  cfg_loaded_q, cfg_loaded_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  err_bad_slot_q, err_drop_desc_q;

  logic                  is_cmd_word, rst_cmd, in_run, can_load, cfg_load;
  logic                  slot_bad, arb_ack;
  logic [1:0]            arb_req, arb_grant;
  logic [DATA_WIDTH-1:0] cfg_word, free_word, lb_word;
  logic                  unused_tlast;

  assign unused_tlast = ctrl_s_tlast;

  assign is_cmd_word = (ctrl_s_tdata == DATA_WIDTH'(CORE_RST_CMD));
  assign rst_cmd     = ctrl_s_tvalid && is_cmd_word;
  assign in_run      = (state_q == ST_RUN);
  assign can_load    = !out_valid_q || ctrl_m_tready;

  // Descriptors only flow to the core in RUN; everything else is swallowed.
  assign desc_tdata    = ctrl_s_tdata;
  assign desc_tvalid   = in_run && ctrl_s_tvalid && !is_cmd_word;
  assign ctrl_s_tready = (in_run && !is_cmd_word) ? desc_tready : 1'b1;

  assign arb_req    = in_run ? {lb_valid, free_valid} : 2'b00;
  assign arb_ack    = in_run && can_load && (arb_grant != 2'b00);
  assign free_ready = arb_ack && arb_grant[0];
  assign lb_ready   = arb_ack && arb_grant[1];
  assign slot_bad   = (free_slot == '0) || (32'(free_slot) > SLOT_COUNT);

  arbiter #(.PORTS(2)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (arb_req),
    .ack_i   (arb_ack),
    .grant_o (arb_grant)
  );

  always_comb begin
    cfg_word = '0;
    cfg_word[DATA_WIDTH-1 -: 4] = MSG_SLOT_CFG;
    cfg_word[SLOT_WIDTH-1:0]    = SLOT_WIDTH'(SLOT_COUNT);

    free_word = '0;
    free_word[DATA_WIDTH-1 -: 4]                 = MSG_SLOT_FREE;
    free_word[LEN_WIDTH+SLOT_WIDTH-1:LEN_WIDTH]  = free_slot;
    free_word[LEN_WIDTH-1:0]                     = free_len;

    lb_word = {MSG_LOOPBACK, lb_data};
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    cfg_loaded_d = cfg_loaded_q;
    cfg_load     = 1'b0;

    unique case (state_q)
      ST_WAIT_CMD: begin
        if (rst_cmd) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (rst_cmd) begin
          hold_cnt_d = HOLD_LOAD;
        end else if (hold_cnt_q == '0) begin
          state_d      = ST_CFG;
          cfg_loaded_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      ST_CFG: begin
        // cfg_loaded_q marks that the register now holds the config word, so the
        // next drain is its handshake; an older word is allowed to finish first.
        if (rst_cmd) begin
          state_d      = ST_HOLD;
          hold_cnt_d   = HOLD_LOAD;
          cfg_loaded_d = 1'b0;
        end else if (!cfg_loaded_q) begin
          if (can_load) begin
            cfg_load     = 1'b1;
            cfg_loaded_d = 1'b1;
          end
        end else if (out_valid_q && ctrl_m_tready) begin
          state_d      = ST_RUN;
          cfg_loaded_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (rst_cmd) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      default: state_d = ST_WAIT_CMD;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_valid_q && ctrl_m_tready) out_valid_d = 1'b0;
    if (cfg_load) begin
      out_valid_d = 1'b1;
      out_data_d  = cfg_word;
    end else if (free_ready && !slot_bad) begin
      out_valid_d = 1'b1;
      out_data_d  = free_word;
    end else if (lb_ready) begin
      out_valid_d = 1'b1;
      out_data_d  = lb_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_WAIT_CMD;
      hold_cnt_q      <= '0;
      cfg_loaded_q    <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      err_bad_slot_q  <= 1'b0;
      err_drop_desc_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_cnt_q      <= hold_cnt_d;
      cfg_loaded_q    <= cfg_loaded_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      err_bad_slot_q  <= free_ready && slot_bad;
      err_drop_desc_q <= ctrl_s_tvalid && !is_cmd_word && !in_run;
    end
  end

  assign ctrl_m_tvalid = out_valid_q;
  assign ctrl_m_tdata  = out_data_q;
  assign ctrl_m_tlast  = 1'b1;
  assign core_rst      = (state_q == ST_WAIT_CMD) || (state_q == ST_HOLD);
  assign err_bad_slot  = err_bad_slot_q;
  assign err_drop_desc = err_drop_desc_q;

endmodule
